// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants for the LPC-to-UART transmit FIFO: byte width, default
// geometry and the pacing FSM state encoding.
package uart_tx_fifo_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned AW_DEF    = 4;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_STROBE    = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/lpc_fifo_ram.sv
// DEPTH x 8 byte storage: one synchronous write port, one asynchronous read
// port. Contents are not reset; occupancy is tracked by the FIFO control.
module lpc_fifo_ram
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [BYTE_W-1:0] rdata_c_o
);

  logic [BYTE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between LPC write strobes and the UART transmitter, with a pacing
// FSM that launches one byte at a time and waits for the transmitter to finish.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH        = DEPTH_DEF,
  parameter int unsigned AW           = AW_DEF,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic              LPC_CLK,
  input  logic              LPC_RST,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_busy,
  output logic [AW:0]       level,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  input  logic              ovf_clear
);

  localparam int unsigned CW       = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

  logic [1:0]        state_q,    state_d;
  logic [AW-1:0]     wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q,   rd_ptr_d;
  logic [AW:0]       level_q,    level_d;
  logic              empty_q,    empty_d;
  logic              full_q,     full_d;
  logic              ovf_q,      ovf_d;
  logic [BYTE_W-1:0] tx_data_q,  tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [CW-1:0]     cnt_q,      cnt_d;

  logic              push_c;
  logic              pop_c;
  logic [BYTE_W-1:0] rd_byte_c;

  lpc_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i     (LPC_CLK),
    .we_i      (push_c),
    .waddr_i   (wr_ptr_q),
    .wdata_i   (wr_data),
    .raddr_i   (rd_ptr_q),
    .rdata_c_o (rd_byte_c)
  );

  // Next-state: pacing FSM, pointers, occupancy and sticky overflow.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    pop_c     = 1'b0;
    push_c    = wr_valid & ~full_q;

    case (state_q)
      ST_IDLE: begin
        if (!empty_q && !tx_busy) begin
          pop_c     = 1'b1;
          tx_data_d = rd_byte_c;
          state_d   = ST_STROBE;
        end
      end
      ST_STROBE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // A transmitter that never raises busy is treated as having taken the byte.
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    tx_valid_d = (state_d == ST_STROBE);

    wr_ptr_d = push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_c  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + (AW+1)'(push_c) - (AW+1)'(pop_c);
    empty_d  = (level_d == '0);
    full_d   = (level_d == LVL_FULL);

    // A dropped write beats a same-cycle clear.
    if (wr_valid && full_q) ovf_d = 1'b1;
    else if (ovf_clear)     ovf_d = 1'b0;
    else                    ovf_d = ovf_q;
  end

  always_ff @(posedge LPC_CLK) begin
    if (!LPC_RST) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign level    = level_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: byte scoreboard against tx strobes,
// a simple UART busy model, a table of fill/overflow vectors and corner sequences.
module tb_uart_tx_fifo;

  logic       LPC_CLK = 1'b0;
  logic       LPC_RST = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_busy = 1'b0;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       ovf_clear = 1'b0;

  always #5 LPC_CLK = ~LPC_CLK;

  uart_tx_fifo #(
    .DEPTH        (16),
    .AW           (4),
    .BUSY_TIMEOUT (4)
  ) dut (
    .LPC_CLK   (LPC_CLK),
    .LPC_RST   (LPC_RST),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_busy   (tx_busy),
    .level     (level),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .ovf_clear (ovf_clear)
  );

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       clr;
    logic       acc;
    int         lvl;
    logic       fl;
    logic       ovf;
  } vec_t;

  vec_t       tbl [21];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         busy_len = -1;   // <0: tx_busy driven by hand; 0: never rises; >0: busy cycles per byte
  int         busy_cnt = 0;
  logic [7:0] exp_q [$];
  int         strb_q [$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // One clock: sample after the edge, score strobes, advance the UART model.
  task automatic tick();
    @(posedge LPC_CLK);
    #1;
    cyc++;
    if (busy_len >= 0) begin
      tx_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
    end
    if (tx_valid) begin
      strb_q.push_back(cyc);
      if (exp_q.size() == 0) chk("stray_strobe", 1, 0);
      else chk("tx_data", int'(tx_data), int'(exp_q.pop_front()));
      if (busy_len > 0) busy_cnt = busy_len;
    end
  endtask

  task automatic put(input logic [7:0] b, input bit acc);
    wr_data  = b;
    wr_valid = 1'b1;
    if (acc) exp_q.push_back(b);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (exp_q.size() > 0 && n < maxc) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout_left", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    LPC_RST = 1'b0;
    tick();
    tick();
    LPC_RST = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int peak;
    int g1;
    int g2;

    for (int i = 0; i < 16; i++)
      tbl[i] = '{1'b1, 8'(8'h10 + i), 1'b0, 1'b1, i + 1, (i == 15), 1'b0};
    tbl[16] = '{1'b1, 8'hEE, 1'b0, 1'b0, 16, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 16, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 8'hEF, 1'b1, 1'b0, 16, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 16, 1'b1, 1'b1};
    tbl[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 16, 1'b1, 1'b0};

    // Reset state
    busy_len = 3;
    do_reset();
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_txv", int'(tx_valid), 0);
    chk("rst_txd", int'(tx_data), 0);

    // Single byte latency: write in N, strobe only in N+2
    put(8'h41, 1'b1);
    chk("t1_level_n1", int'(level), 1);
    chk("t1_txv_n1", int'(tx_valid), 0);
    tick();
    chk("t1_txv_n2", int'(tx_valid), 1);
    chk("t1_level_n2", int'(level), 0);
    tick();
    chk("t1_txv_n3", int'(tx_valid), 0);
    drain(50);
    repeat (10) tick();

    // Three bytes, UART busy 20 cycles each
    strb_q.delete();
    busy_len = 20;
    peak = 0;
    for (int i = 1; i <= 3; i++) begin
      put(8'(i), 1'b1);
      if (int'(level) > peak) peak = int'(level);
    end
    drain(200);
    repeat (25) tick();
    chk("t2_peak_in_2_3", int'(peak >= 2 && peak <= 3), 1);
    chk("t2_strobes", strb_q.size(), 3);
    g1 = (strb_q.size() >= 2) ? strb_q[1] - strb_q[0] : -1;
    g2 = (strb_q.size() >= 3) ? strb_q[2] - strb_q[1] : -1;
    chk("t2_gap1", g1, 23);
    chk("t2_gap2", g2, 23);
    chk("t2_level_end", int'(level), 0);
    chk("t2_empty_end", int'(empty), 1);

    // Busy never rises: WAIT_BUSY timeout paces strobes 6 cycles apart
    strb_q.delete();
    busy_len = 0;
    busy_cnt = 0;
    put(8'h5A, 1'b1);
    put(8'hA5, 1'b1);
    drain(50);
    chk("t3_strobes", strb_q.size(), 2);
    g1 = (strb_q.size() >= 2) ? strb_q[1] - strb_q[0] : -1;
    chk("t3_gap", g1, 6);
    repeat (10) tick();

    // Fill with UART busy, overflow and clear precedence
    busy_len = -1;
    tx_busy = 1'b1;
    do_reset();
    for (int i = 0; i < 21; i++) begin
      wr_valid  = tbl[i].wr;
      wr_data   = tbl[i].d;
      ovf_clear = tbl[i].clr;
      if (tbl[i].wr && tbl[i].acc) exp_q.push_back(tbl[i].d);
      tick();
      chk($sformatf("v%0d_level", i), int'(level), tbl[i].lvl);
      chk($sformatf("v%0d_full", i), int'(full), int'(tbl[i].fl));
      chk($sformatf("v%0d_ovf", i), int'(overflow), int'(tbl[i].ovf));
      chk($sformatf("v%0d_empty", i), int'(empty), 0);
    end
    wr_valid  = 1'b0;
    ovf_clear = 1'b0;

    // Full FIFO: pop and write in the same cycle -> write dropped
    tx_busy  = 1'b0;
    wr_data  = 8'hAA;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("t4_level_popwr", int'(level), 15);
    chk("t4_ovf_popwr", int'(overflow), 1);
    chk("t4_full_popwr", int'(full), 0);
    busy_len = 2;
    busy_cnt = 0;
    drain(400);
    repeat (10) tick();
    chk("t4_level_end", int'(level), 0);
    chk("t4_empty_end", int'(empty), 1);
    chk("t4_ovf_sticky", int'(overflow), 1);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("t4_ovf_cleared", int'(overflow), 0);

    // Reset while in WAIT_DONE with five bytes queued
    busy_len = 30;
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) put(8'(8'h51 + i), 1'b1);
    repeat (3) tick();
    chk("t5_level_pre", int'(level), 5);
    LPC_RST = 1'b0;
    exp_q.delete();
    busy_cnt = 0;
    tick();
    LPC_RST = 1'b1;
    chk("t5_level_rst", int'(level), 0);
    chk("t5_empty_rst", int'(empty), 1);
    chk("t5_full_rst", int'(full), 0);
    chk("t5_txv_rst", int'(tx_valid), 0);
    put(8'h77, 1'b1);
    chk("t5_txv_n1", int'(tx_valid), 0);
    tick();
    chk("t5_txv_n2", int'(tx_valid), 1);
    drain(100);
    repeat (40) tick();
    chk("t5_level_end", int'(level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte FIFO between the LPC device (write-strobe producer) and the UART transmitter (data/data_valid/busy consumer), clocked on LPC_CLK. It absorbs host write bursts that arrive faster than the serial line drains them. A small pacing FSM strobes one byte at a time into the transmitter and waits for it to finish. It exports level, full, empty and overflow so the LPC register logic can report transmitter-holding status.

Parameters:
DEPTH, 16, number of byte entries; power of two, at least 2
AW, 4, pointer width; log2(DEPTH)
BUSY_TIMEOUT, 4, cycles to wait in WAIT_BUSY for tx_busy to rise before treating the byte as accepted

Ports:
LPC_CLK  in  1  sole clock; all state updates on its rising edge
LPC_RST  in  1  synchronous, active-low reset
wr_data  in  8  byte from the LPC device
wr_valid  in  1  single-cycle write strobe; one byte per high cycle
tx_data  out  8  byte presented to the UART transmitter
tx_valid  out  1  single-cycle start strobe to the UART transmitter
tx_busy  in  1  UART transmitter busy
level  out  AW+1  bytes currently stored, 0..DEPTH
empty  out  1  level == 0
full  out  1  level == DEPTH
overflow  out  1  sticky; set when a write is dropped
ovf_clear  in  1  clears overflow

Behaviour:
- Reset, sampled on LPC_CLK while LPC_RST=0:
  - wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0.
  - tx_data=8'h00, tx_valid=0, overflow=0, state=IDLE, timeout counter=0.
  - Reset mid-transfer discards all stored bytes and returns to IDLE at once. tx_valid is 0 in the first cycle after reset.
- Write:
  - wr_valid=1 and full=0: mem[wr_ptr]<=wr_data and wr_ptr increments.
  - wr_valid=1 and full=1: byte dropped, pointers unchanged, overflow<=1.
  - full is the registered value from the start of the cycle. A write into a full FIFO is dropped even if a pop happens in the same cycle.
- Pointers wrap modulo DEPTH. level tracks occupancy and always changes by exactly +1, -1 or 0 (simultaneous push and pop leaves it unchanged).
- overflow: set and ovf_clear in the same cycle -> set wins.
- FSM states: IDLE, STROBE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Pops when empty=0 and tx_busy=0.
  - On pop: tx_data<=mem[rd_ptr], rd_ptr increments, level decrements, go to STROBE.
  - Otherwise stay in IDLE.
- STROBE: tx_valid=1 for exactly this cycle, tx_data stable. Next state WAIT_BUSY, counter cleared.
- WAIT_BUSY:
  - tx_busy=1 -> WAIT_DONE.
  - Otherwise the counter increments. When counter == BUSY_TIMEOUT-1 -> IDLE (byte considered sent).
- WAIT_DONE: tx_busy=0 -> IDLE; otherwise stay.
- tx_valid is registered, high only in STROBE. tx_data holds its value until the next pop.
- Latency: a byte written in cycle N into an empty FIFO with an idle UART gives tx_valid=1 in cycle N+2.
- Back-to-back bytes: the minimum gap between tx_valid strobes is the UART busy time plus 3 cycles.
- Write and pop in the same cycle on a non-empty FIFO: both proceed and level is unchanged.
- Write into an empty FIFO: the FSM sees empty=0 only in the following cycle, so no same-cycle bypass.
- tx_busy already high while in IDLE: no pop until it falls.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, STROBE=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3.
  - Default DEPTH/AW constants.
  - Byte width constant (8).
- One sub-module, lpc_fifo_ram: DEPTH x 8 storage, one synchronous write port, one asynchronous read port, no reset on contents.
- Pointer, level and flag logic, plus the pacing FSM, stay in uart_tx_fifo.

Test Plan:
- Reset then single write of 8'h41 in cycle N with tx_busy=0 -> tx_valid=1, tx_data=8'h41 in cycle N+2 only. Level goes 0->1->0.
- Write 3 bytes 8'h01,8'h02,8'h03 on consecutive cycles; UART model holds busy for 20 cycles after each strobe -> three strobes in order. Each strobe comes after busy falls; level peaks at 2 or 3 and ends at 0, empty=1.
- Hold tx_busy=1, write 17 bytes with DEPTH=16 -> full=1 and level=16 after 16 writes. The 17th write is dropped and overflow=1. Pulse ovf_clear -> overflow=0 while full stays 1.
- tx_busy tied 0 (busy never rises) -> each byte leaves WAIT_BUSY after 4 cycles. 2 bytes give strobes exactly 6 cycles apart.
- FIFO full, pop and write in the same cycle -> write dropped, overflow=1, level becomes 15. Also: ovf_clear and a dropped write in the same cycle -> overflow stays 1.
- Assert LPC_RST=0 for one cycle while in WAIT_DONE with level=5 -> next cycle level=0, empty=1, tx_valid=0, state IDLE. A new write afterwards gives a strobe at N+2.
